// File: rtl/random_engine_arbiter.sv
// random_engine_arbiter: round-robin arbiter and sequencer that shares one
// LFSR random engine among NREQ requesters. One request is in flight at a
// time: accept, start engine, wait (with watchdog), respond, clear engine.
module random_engine_arbiter #(
   parameter int NREQ    = 4,
   parameter int NBITS   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_val,
   output logic [NREQ-1:0]         req_rdy,
   output logic [NREQ-1:0]         resp_val,
   input  logic [NREQ-1:0]         resp_rdy,
   output logic [NBITS-1:0]        resp_data,
   output logic                    resp_err,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy,
   output logic                    eng_go,
   output logic                    eng_clear,
   input  logic                    eng_done_val,
   input  logic [NBITS-1:0]        eng_result
);

   localparam int IDW = $clog2(NREQ);

   localparam logic [2:0] S_CLEAR = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT);

   logic [2:0]     state;
   logic [IDW-1:0] ptr;
   logic [7:0]     cnt;
   logic [IDW-1:0] winner;
   logic           found;
   logic [IDW:0]   idx;

   // Round-robin pick: first set req_val bit scanning upward from ptr, wrapping.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = {1'b0, ptr} + (IDW+1)'(i);
         if (idx >= (IDW+1)'(NREQ)) begin
            idx = idx - (IDW+1)'(NREQ);
         end
         if (!found && req_val[idx[IDW-1:0]]) begin
            winner = idx[IDW-1:0];
            found  = 1'b1;
         end
      end
   end

   // Handshake outputs: Mealy accept in IDLE, Moore response valid in RESP.
   always_comb begin
      req_rdy  = '0;
      resp_val = '0;
      if (state == S_IDLE && found) begin
         req_rdy[winner] = 1'b1;
      end
      if (state == S_RESP) begin
         resp_val[grant_id] = 1'b1;
      end
   end

   // Engine control and status decode straight from state.
   always_comb begin
      busy      = (state != S_IDLE);
      eng_go    = (state == S_START);
      eng_clear = (state == S_CLEAR);
   end

   // Sequencer FSM, grant/pointer registers, watchdog and response registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_CLEAR;
         ptr       <= '0;
         grant_id  <= '0;
         resp_data <= '0;
         resp_err  <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            S_CLEAR: state <= S_IDLE;
            S_IDLE: begin
               if (found) begin
                  grant_id <= winner;
                  state    <= S_START;
               end
            end
            S_START: begin
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               cnt <= cnt + 8'd1;
               if (eng_done_val) begin
                  resp_data <= eng_result;
                  resp_err  <= 1'b0;
                  state     <= S_RESP;
               // Expiry after TIMEOUT+1 WAIT cycles: response lands TIMEOUT+3 after accept.
               end else if (cnt == TO_LAST) begin
                  resp_data <= '0;
                  resp_err  <= 1'b1;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_rdy[grant_id]) begin
                  ptr   <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
                  state <= S_CLEAR;
               end
            end
            default: state <= S_CLEAR;
         endcase
      end
   end

endmodule
